// File: rtl/sounder_sched.sv
// sounder_sched: time-gated snapshot scheduler for a timestamped AXI-Stream.
// Waits for the stream to reach start_time, then passes num_snap bursts of
// snap_len beats, one every snap_period beats, dropping everything else.
//
// Handshake semantics (both stream ports): a beat transfers on a rising clk
// edge where tvalid && tready are both high. A source holds tdata/tvalid and
// sidebands steady until the transfer. While capturing, the input port is a
// zero-latency combinational pass-through of the output port (tready flows
// upstream, tvalid/tdata flow downstream). While not capturing the input is
// always ready and its beats are discarded.
module sounder_sched #(
  parameter int WIDTH = 32,
  parameter int NIPC  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  // configuration / control
  input  logic                    arm,
  input  logic                    abort,
  input  logic [63:0]             start_time,
  input  logic [15:0]             num_snap,
  input  logic [31:0]             snap_len,
  input  logic [31:0]             snap_period,
  // input stream
  input  logic [NIPC*WIDTH-1:0]   i_axis_tdata,
  input  logic                    i_axis_tvalid,
  output logic                    i_axis_tready,
  input  logic [63:0]             i_axis_ttimestamp,
  input  logic                    i_axis_thas_time,
  // output stream
  output logic [NIPC*WIDTH-1:0]   o_axis_tdata,
  output logic                    o_axis_tvalid,
  input  logic                    o_axis_tready,
  output logic                    o_axis_tlast,
  output logic                    o_axis_teob,
  output logic [63:0]             o_axis_ttimestamp,
  output logic                    o_axis_thas_time,
  // status
  output logic                    busy,
  output logic                    late,
  output logic [15:0]             snap_cnt,
  output logic [1:0]              o_dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  logic [1:0]  r_state;
  logic [63:0] r_t_now;
  logic [31:0] r_beat_cnt;
  logic [15:0] r_snap_cnt;
  logic        r_late;
  logic        r_abort_pend;
  logic [63:0] r_start_time;
  logic [15:0] r_num_snap;
  logic [31:0] r_snap_len;
  logic [31:0] r_snap_period;

  logic [63:0] w_beat_time;
  logic [31:0] w_gap_len;
  logic [15:0] w_snap_cnt_inc;
  logic        w_in_hs;
  logic        w_wait_hit;
  logic        w_cap;
  logic        w_out_hs;
  logic        w_first;
  logic        w_last_cnt;
  logic        w_final;
  logic        w_abort_req;
  logic        w_abort_term;

  logic [1:0]  w_eb_state;
  logic [31:0] w_eb_cnt;
  logic [15:0] w_eb_snap;

  logic [1:0]  w_state_nx;
  logic [31:0] w_cnt_nx;
  logic [15:0] w_snap_cnt_nx;
  logic        w_late_nx;
  logic        w_abort_pend_nx;
  logic        w_load;

  // Beat time, capture qualification and output sideband decode.
  always_comb begin
    w_beat_time    = i_axis_thas_time ? i_axis_ttimestamp : r_t_now;
    w_gap_len      = r_snap_period - r_snap_len;
    w_snap_cnt_inc = r_snap_cnt + 16'd1;
    // In WAIT the qualifying beat is itself the first captured beat, so it is
    // presented downstream in the same cycle it is recognised.
    w_wait_hit     = (r_state == S_WAIT) && i_axis_tvalid && !abort &&
                     (w_beat_time >= r_start_time);
    w_cap          = !rst && ((r_state == S_CAPTURE) || w_wait_hit);
    i_axis_tready  = w_cap ? o_axis_tready : 1'b1;
    w_in_hs        = i_axis_tvalid && i_axis_tready;
    w_out_hs       = w_cap && i_axis_tvalid && o_axis_tready;
    w_first        = (r_beat_cnt == 32'd0);
    w_last_cnt     = (r_beat_cnt == (r_snap_len - 32'd1));
    w_final        = (r_num_snap != 16'd0) && (w_snap_cnt_inc == r_num_snap);
    w_abort_req    = abort || r_abort_pend;
    w_abort_term   = (r_state == S_CAPTURE) && w_abort_req;

    o_axis_tvalid     = w_cap && i_axis_tvalid;
    o_axis_tdata      = w_cap ? i_axis_tdata : '0;
    o_axis_thas_time  = o_axis_tvalid && w_first;
    o_axis_ttimestamp = o_axis_thas_time ? w_beat_time : 64'd0;
    o_axis_tlast      = o_axis_tvalid && (w_last_cnt || w_abort_term);
    o_axis_teob       = o_axis_tvalid && ((w_last_cnt && w_final) || w_abort_term);
  end

  // Where a normally completed captured beat leads: next beat, gap, next
  // snapshot or done.
  always_comb begin
    w_eb_state = S_CAPTURE;
    w_eb_cnt   = r_beat_cnt + 32'd1;
    w_eb_snap  = r_snap_cnt;
    if (w_last_cnt) begin
      w_eb_snap = w_snap_cnt_inc;
      w_eb_cnt  = 32'd0;
      if (w_final) begin
        w_eb_state = S_IDLE;
      end else if (r_snap_period > r_snap_len) begin
        w_eb_state = S_GAP;
      end
    end
  end

  // Scheduler next-state logic.
  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_beat_cnt;
    w_snap_cnt_nx   = r_snap_cnt;
    w_late_nx       = r_late;
    w_abort_pend_nx = r_abort_pend;
    w_load          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm && !abort) begin
          w_load          = 1'b1;
          w_state_nx      = S_WAIT;
          w_cnt_nx        = 32'd0;
          w_snap_cnt_nx   = 16'd0;
          w_late_nx       = 1'b0;
          w_abort_pend_nx = 1'b0;
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_state_nx = S_IDLE;
        end else if (w_out_hs) begin
          if (w_beat_time > r_start_time) begin
            w_late_nx = 1'b1;
          end
          w_state_nx    = w_eb_state;
          w_cnt_nx      = w_eb_cnt;
          w_snap_cnt_nx = w_eb_snap;
        end
      end
      S_CAPTURE: begin
        if (w_out_hs) begin
          if (w_abort_req) begin
            // This beat went out with tlast/teob; the run ends here.
            w_state_nx      = S_IDLE;
            w_abort_pend_nx = 1'b0;
            if (w_last_cnt) begin
              w_snap_cnt_nx = w_snap_cnt_inc;
            end
          end else begin
            w_state_nx    = w_eb_state;
            w_cnt_nx      = w_eb_cnt;
            w_snap_cnt_nx = w_eb_snap;
          end
        end else if (w_abort_req) begin
          // A stalled beat still owes its tlast/teob; with nothing pending
          // the run just stops.
          if (i_axis_tvalid) begin
            w_abort_pend_nx = 1'b1;
          end else begin
            w_state_nx      = S_IDLE;
            w_abort_pend_nx = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state_nx = S_IDLE;
        end else if (w_in_hs) begin
          if (r_beat_cnt == (w_gap_len - 32'd1)) begin
            w_state_nx = S_CAPTURE;
            w_cnt_nx   = 32'd0;
          end else begin
            w_cnt_nx = r_beat_cnt + 32'd1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State, counters, stream clock and latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_t_now       <= 64'd0;
      r_beat_cnt    <= 32'd0;
      r_snap_cnt    <= 16'd0;
      r_late        <= 1'b0;
      r_abort_pend  <= 1'b0;
      r_start_time  <= 64'd0;
      r_num_snap    <= 16'd0;
      r_snap_len    <= 32'd1;
      r_snap_period <= 32'd1;
    end else begin
      if (w_in_hs) begin
        r_t_now <= w_beat_time + 64'(NIPC);
      end
      r_state      <= w_state_nx;
      r_beat_cnt   <= w_cnt_nx;
      r_snap_cnt   <= w_snap_cnt_nx;
      r_late       <= w_late_nx;
      r_abort_pend <= w_abort_pend_nx;
      if (w_load) begin
        r_start_time  <= start_time;
        r_num_snap    <= num_snap;
        // A zero-length snapshot is meaningless; run it as one beat.
        r_snap_len    <= (snap_len == 32'd0) ? 32'd1 : snap_len;
        r_snap_period <= snap_period;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign late        = r_late;
  assign snap_cnt    = r_snap_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sounder_sched.sv
// Directed bench for sounder_sched: snapshot bursts, late start, random
// backpressure, continuous mode, abort and reset mid-run.
module tb_sounder_sched;

  localparam int WIDTH = 32;
  localparam int NIPC  = 2;
  localparam int DW    = NIPC * WIDTH;
  localparam int EW    = 3 + 64 + DW;

  logic          clk;
  logic          rst;
  logic          arm;
  logic          abort;
  logic [63:0]   start_time;
  logic [15:0]   num_snap;
  logic [31:0]   snap_len;
  logic [31:0]   snap_period;
  logic [DW-1:0] i_axis_tdata;
  logic          i_axis_tvalid;
  logic          i_axis_tready;
  logic [63:0]   i_axis_ttimestamp;
  logic          i_axis_thas_time;
  logic [DW-1:0] o_axis_tdata;
  logic          o_axis_tvalid;
  logic          o_axis_tready;
  logic          o_axis_tlast;
  logic          o_axis_teob;
  logic [63:0]   o_axis_ttimestamp;
  logic          o_axis_thas_time;
  logic          busy;
  logic          late;
  logic [15:0]   snap_cnt;
  logic [1:0]    o_dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic          chk_stall = 1'b0;
  logic          rand_rdy  = 1'b0;

  sounder_sched #(.WIDTH(WIDTH), .NIPC(NIPC)) dut (
    .clk              (clk),
    .rst              (rst),
    .arm              (arm),
    .abort            (abort),
    .start_time       (start_time),
    .num_snap         (num_snap),
    .snap_len         (snap_len),
    .snap_period      (snap_period),
    .i_axis_tdata     (i_axis_tdata),
    .i_axis_tvalid    (i_axis_tvalid),
    .i_axis_tready    (i_axis_tready),
    .i_axis_ttimestamp(i_axis_ttimestamp),
    .i_axis_thas_time (i_axis_thas_time),
    .o_axis_tdata     (o_axis_tdata),
    .o_axis_tvalid    (o_axis_tvalid),
    .o_axis_tready    (o_axis_tready),
    .o_axis_tlast     (o_axis_tlast),
    .o_axis_teob      (o_axis_teob),
    .o_axis_ttimestamp(o_axis_ttimestamp),
    .o_axis_thas_time (o_axis_thas_time),
    .busy             (busy),
    .late             (late),
    .snap_cnt         (snap_cnt),
    .o_dbg_state      (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [63:0] t);
    return {t[31:0] ^ 32'hA5A5_A5A5, t[31:0]};
  endfunction

  task automatic push_exp(input logic [63:0] t, input logic first, input logic last, input logic eob);
    exp_q.push_back({eob, last, first, (first ? t : 64'd0), mk_data(t)});
  endtask

  // driver tasks (called at posedge+1)
  task automatic send_beat(input logic [63:0] t, input logic ht, input logic ab);
    int n;
    n = 0;
    i_axis_tvalid     = 1'b1;
    i_axis_thas_time  = ht;
    i_axis_ttimestamp = ht ? t : 64'hDEAD_BEEF_0000_0000;
    i_axis_tdata      = mk_data(t);
    abort             = ab;
    @(negedge clk);
    while (!i_axis_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("hs_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    i_axis_tvalid    = 1'b0;
    i_axis_thas_time = 1'b0;
    abort            = 1'b0;
  endtask

  // First beat carries its timestamp; later ones rely on the DUT's t_now.
  task automatic send_run(input logic [63:0] t0, input int n);
    for (int i = 0; i < n; i++) begin
      send_beat(t0 + 64'(2 * i), (i == 0), 1'b0);
    end
  endtask

  task automatic do_arm(input logic [63:0] st, input logic [15:0] ns, input logic [31:0] sl, input logic [31:0] sp);
    start_time  = st;
    num_snap    = ns;
    snap_len    = sl;
    snap_period = sp;
    arm         = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_tvalid"}, 64'(o_axis_tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(o_axis_tlast), 64'd0);
    chk({tag, "_teob"}, 64'(o_axis_teob), 64'd0);
    chk({tag, "_has_time"}, 64'(o_axis_thas_time), 64'd0);
    chk({tag, "_ts"}, o_axis_ttimestamp, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_late"}, 64'(late), 64'd0);
    chk({tag, "_snap_cnt"}, 64'(snap_cnt), 64'd0);
    chk({tag, "_state"}, 64'(o_dbg_state), 64'd0);
  endtask

  // random backpressure
  always @(posedge clk) begin
    #1;
    if (rand_rdy) o_axis_tready = 1'($urandom_range(0, 1));
  end

  // scoreboard: every output handshake must match the head of exp_q
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (o_axis_tvalid && o_axis_tready) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data", o_axis_tdata, e[DW-1:0]);
        chk("ts", o_axis_ttimestamp, e[DW+63:DW]);
        chk("has_time", 64'(o_axis_thas_time), 64'(e[DW+64]));
        chk("tlast", 64'(o_axis_tlast), 64'(e[DW+65]));
        chk("teob", 64'(o_axis_teob), 64'(e[DW+66]));
      end
    end
    if (chk_stall && o_axis_tvalid) chk("stall_match", 64'(i_axis_tready), 64'(o_axis_tready));
  end

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0;
    start_time = '0; num_snap = '0; snap_len = '0; snap_period = '0;
    i_axis_tdata = '0; i_axis_tvalid = 1'b0; i_axis_ttimestamp = '0; i_axis_thas_time = 1'b0;
    o_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    outputs_zero("reset");
    @(posedge clk);
    #1;

    // three 4-beat snapshots every 10 beats from time 100
    for (int s = 0; s < 3; s++)
      for (int b = 0; b < 4; b++)
        push_exp(64'(100 + 20 * s + 2 * b), (b == 0), (b == 3), (s == 2 && b == 3));
    do_arm(64'd100, 16'd3, 32'd4, 32'd10);
    @(negedge clk);
    chk("armed_busy", 64'(busy), 64'd1);
    chk("armed_state", 64'(o_dbg_state), 64'd1);
    @(posedge clk);
    #1;
    send_run(64'd0, 81);
    @(negedge clk);
    chk("t1_snap_cnt", 64'(snap_cnt), 64'd3);
    chk("t1_late", 64'(late), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // late start: stream already at 200
    push_exp(64'd200, 1'b1, 1'b0, 1'b0);
    push_exp(64'd202, 1'b0, 1'b0, 1'b0);
    push_exp(64'd204, 1'b0, 1'b1, 1'b1);
    do_arm(64'd50, 16'd1, 32'd3, 32'd3);
    send_run(64'd200, 6);
    @(negedge clk);
    chk("t2_late", 64'(late), 64'd1);
    chk("t2_snap_cnt", 64'(snap_cnt), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // back-to-back snapshots under random backpressure
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < 5; b++)
        push_exp(64'(300 + 10 * s + 2 * b), (b == 0), (b == 4), (s == 1 && b == 4));
    do_arm(64'd300, 16'd2, 32'd5, 32'd5);
    chk_stall = 1'b1;
    rand_rdy  = 1'b1;
    send_run(64'd296, 18);
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    o_axis_tready = 1'b1;
    chk_stall     = 1'b0;
    @(negedge clk);
    chk("t3_snap_cnt", 64'(snap_cnt), 64'd2);
    chk("t3_late", 64'(late), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // continuous mode, then abort with no beat pending
    for (int i = 0; i < 12; i++)
      push_exp(64'(400 + 2 * i), (i % 4 == 0), (i % 4 == 3), 1'b0);
    do_arm(64'd400, 16'd0, 32'd4, 32'd4);
    send_run(64'd400, 12);
    @(negedge clk);
    chk("t4_snap_cnt", 64'(snap_cnt), 64'd3);
    chk("t4_state", 64'(o_dbg_state), 64'd2);
    chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t4_abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // abort on beat 2 of a 4-beat snapshot
    push_exp(64'd500, 1'b1, 1'b0, 1'b0);
    push_exp(64'd502, 1'b0, 1'b1, 1'b1);
    do_arm(64'd500, 16'd0, 32'd4, 32'd8);
    send_beat(64'd500, 1'b1, 1'b0);
    send_beat(64'd502, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    send_beat(64'd504, 1'b0, 1'b0);
    send_beat(64'd506, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // reset while in GAP
    push_exp(64'd700, 1'b1, 1'b0, 1'b0);
    push_exp(64'd702, 1'b0, 1'b1, 1'b0);
    do_arm(64'd700, 16'd0, 32'd2, 32'd6);
    send_run(64'd700, 3);
    @(negedge clk);
    chk("t6_in_gap", 64'(o_dbg_state), 64'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    arm = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    arm = 1'b0;
    @(negedge clk);
    outputs_zero("rst_gap");
    @(posedge clk);
    #1;

    // reset while a captured beat is stalled
    push_exp(64'd800, 1'b1, 1'b0, 1'b0);
    do_arm(64'd800, 16'd0, 32'd4, 32'd4);
    send_beat(64'd800, 1'b1, 1'b0);
    i_axis_tvalid     = 1'b1;
    i_axis_thas_time  = 1'b0;
    i_axis_tdata      = mk_data(64'd802);
    o_axis_tready     = 1'b0;
    @(negedge clk);
    chk("t7_stall_ready", 64'(i_axis_tready), 64'd0);
    chk("t7_stall_valid", 64'(o_axis_tvalid), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_valid", 64'(o_axis_tvalid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    o_axis_tready = 1'b1;
    @(negedge clk);
    outputs_zero("rst_cap");
    chk("t7_discard_ready", 64'(i_axis_tready), 64'd1);
    @(posedge clk);
    #1;
    i_axis_tvalid = 1'b0;

    // clean restart with snap_len 0 treated as a single beat
    push_exp(64'd900, 1'b1, 1'b1, 1'b1);
    do_arm(64'd900, 16'd1, 32'd0, 32'd0);
    send_run(64'd900, 2);
    @(negedge clk);
    chk("t8_snap_cnt", 64'(snap_cnt), 64'd1);
    chk("t8_late", 64'(late), 64'd0);
    chk("t8_busy", 64'(busy), 64'd0);
    chk("t8_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sounder_sched.md
SOUNDER_SCHED -- requirements
Module: sounder_sched

Interface
REQ-001 SHALL have parameters: WIDTH, default 32, bits per item; NIPC, default 2, items per beat.
REQ-002 SHALL have ports, clock and reset first: clk in 1, clock; rst in 1, reset. Reset rst is synchronous and active-high; clock clk.
REQ-003 SHALL have config ports: arm in 1, one-cycle start request; abort in 1, one-cycle stop request; start_time in 64, item time at which capture begins; num_snap in 16, snapshot count, 0 = continuous; snap_len in 32, beats per snapshot; snap_period in 32, beats from snapshot start to next snapshot start.
REQ-004 SHALL have input stream ports: i_axis_tdata in NIPC*WIDTH; i_axis_tvalid in 1; i_axis_tready out 1; i_axis_ttimestamp in 64; i_axis_thas_time in 1.
REQ-005 SHALL have output stream ports: o_axis_tdata out NIPC*WIDTH; o_axis_tvalid out 1; o_axis_tready in 1; o_axis_tlast out 1; o_axis_teob out 1; o_axis_ttimestamp out 64; o_axis_thas_time out 1.
REQ-006 SHALL have status ports: busy out 1, state != IDLE; late out 1, sticky late-start flag; snap_cnt out 16, completed snapshots.

Function
REQ-007 SHALL track beat time: on every input handshake, beat_time = ttimestamp if thas_time, else t_now; t_now <= beat_time + NIPC.
REQ-008 SHALL implement states IDLE, WAIT, CAPTURE, GAP.
REQ-009 SHALL latch start_time, num_snap, snap_len, snap_period on arm in IDLE; arm outside IDLE SHALL be ignored.
REQ-010 IDLE: arm -> WAIT; clear snap_cnt and late on that transition.
REQ-011 WAIT: on the first input beat with beat_time >= start_time, SHALL enter CAPTURE, and that beat SHALL be the first captured beat; if beat_time > start_time, late SHALL be set.
REQ-012 CAPTURE: SHALL pass exactly snap_len beats; after the last one, snap_cnt SHALL increment and the block SHALL go to IDLE if snap_cnt+1 == num_snap (num_snap != 0), else to GAP if snap_period > snap_len, else stay in CAPTURE and start the next snapshot.
REQ-013 GAP: SHALL drop snap_period - snap_len beats, then enter CAPTURE.
REQ-014 Beat counter SHALL be 32 bits, count handshaked beats only, and reset to 0 at each snapshot/gap start.
REQ-015 In CAPTURE: o_axis_tdata = i_axis_tdata; o_axis_tvalid = i_axis_tvalid; i_axis_tready = o_axis_tready. This path SHALL be combinational, with 0 latency.
REQ-016 In IDLE, WAIT and GAP: i_axis_tready = 1 and o_axis_tvalid = 0 (input discarded).
REQ-017 o_axis_thas_time = 1 and o_axis_ttimestamp = beat_time on the first beat of each snapshot; both SHALL be 0 otherwise.
REQ-018 o_axis_tlast = 1 on the last beat of each snapshot.
REQ-019 o_axis_teob = 1 on the last beat of the final snapshot (num_snap != 0), or on the abort-terminated beat.
REQ-020 abort in WAIT or GAP SHALL go to IDLE next cycle with no output.
REQ-021 abort in CAPTURE SHALL terminate at the next output handshake, which carries tlast=1 and teob=1. If no beat is pending, the block SHALL go to IDLE and emit nothing further.
REQ-022 abort and arm in the same cycle: abort SHALL win.
REQ-023 snap_len == 0 is illegal and SHALL be treated as 1.
REQ-024 snap_cnt SHALL wrap modulo 2^16 in continuous mode.

Reset
REQ-025 On rst: state IDLE, t_now 0, beat counter 0, snap_cnt 0, late 0, busy 0, o_axis_tvalid 0, tlast/teob/thas_time 0, o_axis_ttimestamp 0. rst SHALL override arm and abort.
REQ-026 rst mid-CAPTURE SHALL drop the snapshot with no tlast/teob emitted; a held input beat SHALL be discarded.

Verification
REQ-027 Input timestamps from 0, NIPC=2; start_time=100, num_snap=3, snap_len=4, snap_period=10 -> three 4-beat bursts with timestamps 100, 120, 140; tlast on beats 4, 8, 12; teob on beat 12; snap_cnt=3; late=0.
REQ-028 Arm with start_time=50 while stream time is 200 -> capture starts at the first beat with timestamp 200; late=1.
REQ-029 o_axis_tready toggled randomly during CAPTURE -> no beat lost or duplicated; input stalls exactly when the output stalls; output data equals the input sequence.
REQ-030 snap_period=snap_len=4, num_snap=0 -> continuous output; tlast every 4 beats; thas_time every 4 beats; no teob; snap_cnt increments.
REQ-031 abort on beat 2 of a 4-beat snapshot -> beat 2 (or the next handshake) carries tlast=1 and teob=1; busy=0 the next cycle.
REQ-032 rst asserted in GAP and in CAPTURE -> all outputs 0 the next cycle; a later arm restarts cleanly.
